// File: rtl/main_memory.sv
// main_memory: fixed-latency backing store behind the cache.
// It serves one refill or write-back at a time and signals each completion
// with a single-cycle ready_mem pulse. Refill data stays on data_in_mem
// until the next read completes.

module main_memory #(
   parameter int BLOCK_SIZE = 128,
   parameter int ADDR_WIDTH = 30,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_req,
   input  logic                  write_req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [BLOCK_SIZE-1:0] dirty_block_in,
   output logic                  busy,
   output logic                  ready_mem,
   output logic [BLOCK_SIZE-1:0] data_in_mem
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx_q;
   logic [BLOCK_SIZE-1:0] data_q;
   logic [BLOCK_SIZE-1:0] mem [DEPTH];

   // Upper address bits only select aliases of the same entry, so they are
   // intentionally dropped; this reduction just marks them as consumed.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr;

   // Request sequencing: accept in IDLE/RESP (write wins), count down the
   // latency in RD/WR, then pulse ready_mem for one cycle in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         ready_mem   <= 1'b0;
         data_in_mem <= '0;
         cnt         <= '0;
      end else begin
         ready_mem <= 1'b0;
         unique case (state)
            IDLE, RESP: begin
               if (write_req) begin
                  idx_q  <= addr[IDX_W-1:0];
                  data_q <= dirty_block_in;
                  cnt    <= CNT_LOAD;
                  state  <= WR;
                  busy   <= 1'b1;
               end else if (read_req) begin
                  idx_q <= addr[IDX_W-1:0];
                  cnt   <= CNT_LOAD;
                  state <= RD;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RD, WR: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (state == RD) begin
                     data_in_mem <= mem[idx_q];
                  end
                  ready_mem <= 1'b1;
                  busy      <= 1'b0;
                  state     <= RESP;
               end
            end
         endcase
      end
   end

   // Storage array: a write lands only on its completion edge, and a reset
   // on that same edge discards it. Contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && state == WR && cnt == '0) begin
         mem[idx_q] <= data_q;
      end
   end

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed and randomized checks of main_memory against a
// simple reference: an associative array keyed by addr mod DEPTH, with every
// completion expected exactly LATENCY edges after acceptance.

module tb_main_memory;

   localparam int BS    = 128;
   localparam int AW    = 30;
   localparam int DEPTH = 1024;
   localparam int LAT   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          read_req;
   logic          write_req;
   logic [AW-1:0] addr;
   logic [BS-1:0] dirty_block_in;
   logic          busy;
   logic          ready_mem;
   logic [BS-1:0] data_in_mem;

   int checks_total  = 0;
   int checks_passed = 0;

   logic [BS-1:0] ref_mem [int];

   main_memory #(
      .BLOCK_SIZE (BS),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .LATENCY    (LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .read_req       (read_req),
      .write_req      (write_req),
      .addr           (addr),
      .dirty_block_in (dirty_block_in),
      .busy           (busy),
      .ready_mem      (ready_mem),
      .data_in_mem    (data_in_mem)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle just past it before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [BS-1:0] observed,
                               input logic [BS-1:0] expected);
      checks_total++;
      assert (observed === expected) checks_passed++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   function automatic int key_of(input logic [AW-1:0] a);
      return int'(a) % DEPTH;
   endfunction

   function automatic logic [BS-1:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Issue one request and watch LAT+4 cycles: first-pulse latency, busy
   // cycle count, pulse count and the data seen with the first pulse.
   task automatic apply_stimulus(input bit do_wr, input bit do_rd,
                                 input logic [AW-1:0] a, input logic [BS-1:0] d,
                                 input bit noise, output int lat,
                                 output int busy_cycles, output int pulses,
                                 output logic [BS-1:0] rdata);
      read_req       = do_rd;
      write_req      = do_wr;
      addr           = a;
      dirty_block_in = d;
      tick();
      read_req       = 1'b0;
      write_req      = 1'b0;
      addr           = AW'($urandom);
      dirty_block_in = rand_block();
      lat            = -1;
      busy_cycles    = 0;
      pulses         = 0;
      rdata          = 'x;
      for (int k = 0; k < LAT + 4; k++) begin
         if (busy) busy_cycles++;
         if (ready_mem) begin
            pulses++;
            if (lat < 0) begin
               lat   = k;
               rdata = data_in_mem;
            end
         end
         if (noise && k == 1) read_req = 1'b1;
         if (noise && k == 2) read_req = 1'b0;
         tick();
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [BS-1:0] d,
                           input bit also_rd, input bit noise, input string tag);
      int lat, bc, np;
      logic [BS-1:0] rd;
      apply_stimulus(1'b1, also_rd, a, d, noise, lat, bc, np, rd);
      check_output({tag, "_lat"}, BS'(lat), BS'(LAT));
      check_output({tag, "_busy"}, BS'(bc), BS'(LAT));
      check_output({tag, "_pulses"}, BS'(np), BS'(1));
      ref_mem[key_of(a)] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input string tag);
      int lat, bc, np;
      logic [BS-1:0] rd;
      apply_stimulus(1'b0, 1'b1, a, '0, 1'b0, lat, bc, np, rd);
      check_output({tag, "_lat"}, BS'(lat), BS'(LAT));
      check_output({tag, "_busy"}, BS'(bc), BS'(LAT));
      check_output({tag, "_pulses"}, BS'(np), BS'(1));
      if (ref_mem.exists(key_of(a))) begin
         check_output({tag, "_data"}, rd, ref_mem[key_of(a)]);
      end
   endtask

   initial begin
      logic [BS-1:0] val_a, val_b, val_7, ones;
      logic [AW-1:0] ra;
      int            gap, np;
      bit            found;

      // Reset held with both requests asserted
      rst            = 1'b1;
      read_req       = 1'b1;
      write_req      = 1'b1;
      addr           = AW'(1);
      dirty_block_in = rand_block();
      for (int i = 0; i < 2; i++) begin
         tick();
         check_output("rst_busy", BS'(busy), BS'(0));
         check_output("rst_ready", BS'(ready_mem), BS'(0));
         check_output("rst_data", data_in_mem, '0);
      end
      rst       = 1'b0;
      read_req  = 1'b0;
      write_req = 1'b0;
      np        = 0;
      for (int i = 0; i < LAT + 3; i++) begin
         tick();
         if (ready_mem || busy) np++;
      end
      check_output("rst_release_quiet", BS'(np), BS'(0));

      // Write then read
      do_write(AW'(32'h0000_00C1), 128'hCAFEBABE_F0F0AAAA_1C78F0F0_F0F0F0F0,
               1'b0, 1'b0, "wr_c1");
      do_read(AW'(32'h0000_00C1), "rd_c1");

      // Simultaneous requests: write wins, single pulse
      ones = {32{4'h1}};
      do_write(AW'(5), ones, 1'b1, 1'b0, "both_5");
      do_read(AW'(5), "rd_5");

      // Back-to-back: read accepted during the write's RESP cycle
      val_7          = rand_block();
      write_req      = 1'b1;
      addr           = AW'(7);
      dirty_block_in = val_7;
      tick();
      write_req = 1'b0;
      found     = 1'b0;
      for (int k = 0; k < LAT + 3 && !found; k++) begin
         if (ready_mem) found = 1'b1;
         else tick();
      end
      check_output("b2b_first_pulse", BS'(found), BS'(1));
      read_req = 1'b1;
      addr     = AW'(7);
      tick();
      read_req = 1'b0;
      check_output("b2b_accept_busy", BS'(busy), BS'(1));
      gap   = 1;
      found = 1'b0;
      while (!found && gap <= LAT + 4) begin
         if (ready_mem) found = 1'b1;
         else begin
            tick();
            gap++;
         end
      end
      check_output("b2b_gap", BS'(gap), BS'(LAT + 1));
      check_output("b2b_data", data_in_mem, val_7);
      ref_mem[7] = val_7;
      for (int i = 0; i < 3; i++) tick();

      // Busy rejection, then aliasing through the upper address bits
      do_write(AW'(32'h0000_0011), rand_block(), 1'b0, 1'b1, "busy_reject");
      do_write(AW'(32'h3FF0_0002), rand_block(), 1'b0, 1'b0, "alias_wr");
      do_read(AW'(32'h0000_0002), "alias_rd");

      // Reset in the middle of a write
      val_a = rand_block();
      val_b = ~val_a;
      do_write(AW'(9), val_a, 1'b0, 1'b0, "pre_abort");
      write_req      = 1'b1;
      addr           = AW'(9);
      dirty_block_in = val_b;
      tick();
      write_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("abort_busy", BS'(busy), BS'(0));
      check_output("abort_ready", BS'(ready_mem), BS'(0));
      check_output("abort_data", data_in_mem, '0);
      np = 0;
      for (int i = 0; i < LAT + 3; i++) begin
         tick();
         if (ready_mem) np++;
      end
      check_output("abort_no_pulse", BS'(np), BS'(0));
      do_read(AW'(9), "abort_rd");

      // Randomized traffic over a small index pool with random upper bits
      for (int n = 0; n < 24; n++) begin
         ra = (AW'($urandom) & ~AW'(DEPTH - 1)) | AW'(16 + $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            do_write(ra, rand_block(), 1'(($urandom_range(0, 3) == 0)), 1'b0, "rnd_wr");
         end else begin
            do_read(ra, "rnd_rd");
         end
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
